// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-to-binary converter family.
package sc_pkg;

  typedef enum logic [1:0] {SBC_IDLE, SBC_RUN, SBC_DONE} sbc_state_t;

  localparam int unsigned SAT_MAXW = 16;

  // Clamp a (w+1)-bit count to the largest w-bit value.
  function automatic logic [SAT_MAXW-1:0] sat(input logic [SAT_MAXW:0] v, input int unsigned w);
    logic [SAT_MAXW:0] lim;
    lim = (SAT_MAXW+1)'(1) << w;
    if (v >= lim) sat = SAT_MAXW'(lim - (SAT_MAXW+1)'(1));
    else          sat = SAT_MAXW'(v);
  endfunction

endpackage

// File: rtl/sbc_et_ckpt.sv
// Checkpoint detector: spots power-of-two bit counts, scales the running count
// to full precision and compares it against the previous checkpoint estimate.
module sbc_et_ckpt #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ET_MIN    = 4,
  parameter int unsigned ET_THRESH = 8
) (
  input  logic [WIDTH:0] n_nx,
  input  logic [WIDTH:0] cnt_nx,
  input  logic [WIDTH:0] est_prev,
  input  logic           have_prev,
  input  logic           et_en_q,
  output logic           is_ckpt,
  output logic [WIDTH:0] est_k,
  output logic           hit
);

  localparam int unsigned CW = WIDTH + 1;

  logic [CW-1:0] diff;

  always_comb begin
    is_ckpt = 1'b0;
    est_k   = '0;
    for (int unsigned k = ET_MIN; k < WIDTH; k++) begin
      if (n_nx == (CW'(1) << k)) begin
        is_ckpt = 1'b1;
        est_k   = cnt_nx << (WIDTH - k);
      end
    end
    diff = (est_k >= est_prev) ? (est_k - est_prev) : (est_prev - est_k);
    hit  = is_ckpt & et_en_q & have_prev & (diff <= CW'(ET_THRESH));
  end

endmodule

// File: rtl/sbc_et.sv
// Stochastic-to-binary converter: counts ones in a unipolar stream and stops
// early once two consecutive power-of-two checkpoint estimates agree.
module sbc_et
  import sc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ET_MIN    = 4,
  parameter int unsigned ET_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             et_en,
  input  logic             pz_valid,
  input  logic             pz,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Bz,
  output logic [WIDTH:0]   cycles_used,
  output logic             early
);

  localparam int unsigned   CW     = WIDTH + 1;
  localparam logic [CW-1:0] N_FULL = CW'(1) << WIDTH;

  sbc_state_t       state, state_nx;
  logic [CW-1:0]    n, n_d, cnt, cnt_d, est_prev, est_prev_d, cycles_used_d;
  logic             have_prev, have_prev_d, et_en_q, et_en_q_d, early_d, start_acc;
  logic [WIDTH-1:0] bz_d;
  logic [CW-1:0]    n_nx, cnt_nx, est_k;
  logic             is_ckpt, hit;

  assign n_nx   = n + CW'(1);
  assign cnt_nx = cnt + CW'(pz);

  sbc_et_ckpt #(
    .WIDTH     (WIDTH),
    .ET_MIN    (ET_MIN),
    .ET_THRESH (ET_THRESH)
  ) u_ckpt (
    .n_nx      (n_nx),
    .cnt_nx    (cnt_nx),
    .est_prev  (est_prev),
    .have_prev (have_prev),
    .et_en_q   (et_en_q),
    .is_ckpt   (is_ckpt),
    .est_k     (est_k),
    .hit       (hit)
  );

  // Next-state and datapath update; early hit wins over full-length end.
  always_comb begin
    state_nx      = state;
    n_d           = n;
    cnt_d         = cnt;
    est_prev_d    = est_prev;
    have_prev_d   = have_prev;
    et_en_q_d     = et_en_q;
    bz_d          = Bz;
    cycles_used_d = cycles_used;
    early_d       = early;
    start_acc     = 1'b0;

    case (state)
      SBC_IDLE: begin
        if (start) start_acc = 1'b1;
      end
      SBC_RUN: begin
        if (pz_valid) begin
          n_d   = n_nx;
          cnt_d = cnt_nx;
          if (hit) begin
            state_nx      = SBC_DONE;
            early_d       = 1'b1;
            bz_d          = WIDTH'(sat((SAT_MAXW+1)'(est_k), WIDTH));
            cycles_used_d = n_nx;
          end else if (n_nx == N_FULL) begin
            state_nx      = SBC_DONE;
            early_d       = 1'b0;
            bz_d          = WIDTH'(sat((SAT_MAXW+1)'(cnt_nx), WIDTH));
            cycles_used_d = n_nx;
          end else if (is_ckpt) begin
            est_prev_d  = est_k;
            have_prev_d = 1'b1;
          end
        end
      end
      SBC_DONE: begin
        if (out_ready) begin
          state_nx = SBC_IDLE;
          if (start) start_acc = 1'b1;
        end
      end
      default: state_nx = SBC_IDLE;
    endcase

    if (start_acc) begin
      state_nx    = SBC_RUN;
      n_d         = '0;
      cnt_d       = '0;
      est_prev_d  = '0;
      have_prev_d = 1'b0;
      et_en_q_d   = et_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SBC_IDLE;
      n           <= '0;
      cnt         <= '0;
      est_prev    <= '0;
      have_prev   <= 1'b0;
      et_en_q     <= 1'b0;
      Bz          <= '0;
      cycles_used <= '0;
      early       <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_nx;
      n           <= n_d;
      cnt         <= cnt_d;
      est_prev    <= est_prev_d;
      have_prev   <= have_prev_d;
      et_en_q     <= et_en_q_d;
      Bz          <= bz_d;
      cycles_used <= cycles_used_d;
      early       <= early_d;
      busy        <= (state_nx == SBC_RUN);
      out_valid   <= (state_nx == SBC_DONE);
    end
  end

endmodule

// File: tb/tb_sbc_et.sv
// Directed bench for sbc_et with WIDTH=8, ET_MIN=4, ET_THRESH=8.
module tb_sbc_et;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       et_en = 1'b0;
  logic       pz_valid = 1'b0;
  logic       pz = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, out_valid, early;
  logic [7:0] Bz;
  logic [8:0] cycles_used;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sbc_et #(.WIDTH(8), .ET_MIN(4), .ET_THRESH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .et_en       (et_en),
    .pz_valid    (pz_valid),
    .pz          (pz),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Bz          (Bz),
    .cycles_used (cycles_used),
    .early       (early)
  );

  // 0: all ones, 1: alternating 1,0, 2: all zeros, 3: 64 ones then zeros
  function automatic logic stream_bit(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 2 == 0);
      2:       return 1'b0;
      default: return (i < 64);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_conv(input logic et);
    start = 1'b1;
    et_en = et;
    tick();
    start = 1'b0;
    et_en = 1'b0;
  endtask

  // Invalid cycles carry pz=1 so a converter that counts them gets caught.
  task automatic feed(input int mode, input bit sparse, input int limit,
                      output int bits, output int clks);
    bits = 0;
    clks = 0;
    while (!out_valid && bits < limit && clks < 1000) begin
      if (sparse && (clks % 2 == 1)) begin
        pz_valid = 1'b0;
        pz       = 1'b1;
      end else begin
        pz_valid = 1'b1;
        pz       = stream_bit(mode, bits);
        bits++;
      end
      tick();
      clks++;
    end
    pz_valid = 1'b0;
    pz       = 1'b0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL reset_early: got %b want 0", early); end
    vectors++; if (Bz !== 8'd0) begin miscompares++; $display("FAIL reset_bz: got %0d want 0", Bz); end
    vectors++; if (cycles_used !== 9'd0) begin miscompares++; $display("FAIL reset_cycles: got %0d want 0", cycles_used); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_ones();
    int b, c;
    begin_conv(1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ones_busy: got %b want 1", busy); end
    feed(0, 1'b0, 1000, b, c);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ones_valid: got %b want 1", out_valid); end
    vectors++; if (Bz !== 8'd255) begin miscompares++; $display("FAIL ones_bz: got %0d want 255", Bz); end
    vectors++; if (cycles_used !== 9'd256) begin miscompares++; $display("FAIL ones_cycles: got %0d want 256", cycles_used); end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL ones_early: got %b want 0", early); end
    vectors++; if (c != 256) begin miscompares++; $display("FAIL ones_latency: got %0d clocks want 256", c); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ones_busy_done: got %b want 0", busy); end
    ack();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ones_ack_valid: got %b want 0", out_valid); end
    vectors++; if (Bz !== 8'd255) begin miscompares++; $display("FAIL ones_idle_bz: got %0d want 255", Bz); end
  endtask

  task automatic test_alternating();
    int b, c;
    begin_conv(1'b1);
    feed(1, 1'b0, 1000, b, c);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL alt_valid: got %b want 1", out_valid); end
    vectors++; if (Bz !== 8'd128) begin miscompares++; $display("FAIL alt_bz: got %0d want 128", Bz); end
    vectors++; if (cycles_used !== 9'd32) begin miscompares++; $display("FAIL alt_cycles: got %0d want 32", cycles_used); end
    vectors++; if (early !== 1'b1) begin miscompares++; $display("FAIL alt_early: got %b want 1", early); end
    vectors++; if (c != 32) begin miscompares++; $display("FAIL alt_latency: got %0d clocks want 32", c); end
    ack();
  endtask

  task automatic test_zeros();
    int b, c;
    begin_conv(1'b1);
    feed(2, 1'b0, 1000, b, c);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL zeros_valid: got %b want 1", out_valid); end
    vectors++; if (Bz !== 8'd0) begin miscompares++; $display("FAIL zeros_bz: got %0d want 0", Bz); end
    vectors++; if (cycles_used !== 9'd32) begin miscompares++; $display("FAIL zeros_cycles: got %0d want 32", cycles_used); end
    vectors++; if (early !== 1'b1) begin miscompares++; $display("FAIL zeros_early: got %b want 1", early); end
    ack();
  endtask

  task automatic test_sparse();
    int b, c;
    begin_conv(1'b1);
    feed(1, 1'b1, 1000, b, c);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sparse_valid: got %b want 1", out_valid); end
    vectors++; if (Bz !== 8'd128) begin miscompares++; $display("FAIL sparse_bz: got %0d want 128", Bz); end
    vectors++; if (cycles_used !== 9'd32) begin miscompares++; $display("FAIL sparse_cycles: got %0d want 32", cycles_used); end
    vectors++; if (c != 63) begin miscompares++; $display("FAIL sparse_latency: got %0d clocks want 63", c); end
    ack();
  endtask

  task automatic test_ones_then_zeros();
    int b, c;
    begin_conv(1'b1);
    feed(3, 1'b0, 1000, b, c);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL o64_valid: got %b want 1", out_valid); end
    vectors++; if (Bz !== 8'd255) begin miscompares++; $display("FAIL o64_bz: got %0d want 255", Bz); end
    vectors++; if (cycles_used !== 9'd32) begin miscompares++; $display("FAIL o64_cycles: got %0d want 32", cycles_used); end
    vectors++; if (early !== 1'b1) begin miscompares++; $display("FAIL o64_early: got %b want 1", early); end
    ack();
  endtask

  task automatic test_reset_mid();
    int b, c;
    begin_conv(1'b0);
    feed(0, 1'b0, 100, b, c);
    vectors++; if (busy !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_running: got busy=%b valid=%b want 1/0", busy, out_valid); end
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({busy, out_valid, early, Bz, cycles_used} !== 20'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b valid=%b early=%b bz=%0d cycles=%0d want all 0", busy, out_valid, early, Bz, cycles_used);
    end
    rst_n = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_after: got busy=%b valid=%b want 0/0", busy, out_valid); end
    begin_conv(1'b0);
    feed(1, 1'b0, 1000, b, c);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_fresh_valid: got %b want 1", out_valid); end
    vectors++; if (Bz !== 8'd128) begin miscompares++; $display("FAIL mid_fresh_bz: got %0d want 128", Bz); end
    vectors++; if (cycles_used !== 9'd256) begin miscompares++; $display("FAIL mid_fresh_cycles: got %0d want 256", cycles_used); end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL mid_fresh_early: got %b want 0", early); end
    ack();
  endtask

  task automatic test_back_to_back();
    int b, c;
    begin_conv(1'b1);
    feed(1, 1'b0, 1000, b, c);
    // Hold with start asserted but no out_ready: nothing may move.
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      et_en     = 1'b0;
      pz_valid  = 1'b1;
      pz        = (i % 2 == 0);
      tick();
      vectors++;
      if ({out_valid, busy, early, Bz, cycles_used} !== {1'b1, 1'b0, 1'b1, 8'd128, 9'd32}) begin
        miscompares++;
        $display("FAIL hold_%0d: got valid=%b busy=%b early=%b bz=%0d cycles=%0d want 1/0/1/128/32",
                 i, out_valid, busy, early, Bz, cycles_used);
      end
    end
    pz_valid  = 1'b0;
    pz        = 1'b0;
    start     = 1'b1;
    et_en     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    et_en     = 1'b0;
    out_ready = 1'b0;
    vectors++; if (busy !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_restart: got busy=%b valid=%b want 1/0", busy, out_valid); end
    feed(2, 1'b0, 1000, b, c);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    vectors++; if (Bz !== 8'd0) begin miscompares++; $display("FAIL b2b_bz: got %0d want 0", Bz); end
    vectors++; if (cycles_used !== 9'd32) begin miscompares++; $display("FAIL b2b_cycles: got %0d want 32", cycles_used); end
    vectors++; if (early !== 1'b1) begin miscompares++; $display("FAIL b2b_early: got %b want 1", early); end
    ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_ones();
    test_alternating();
    test_zeros();
    test_sparse();
    test_ones_then_zeros();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
